// File: rtl/aes_regfile_pkg.sv
// Shared constants and types for the AES register file: address map, FSM states,
// status bit positions and SPI transaction width encodings.
package aes_regfile_pkg;

    localparam logic [3:0] ADDR_KEY0 = 4'd0;
    localparam logic [3:0] ADDR_KEY3 = 4'd3;
    localparam logic [3:0] ADDR_DIN0 = 4'd4;
    localparam logic [3:0] ADDR_DIN3 = 4'd7;
    localparam logic [3:0] ADDR_DOUT0 = 4'd8;
    localparam logic [3:0] ADDR_DOUT3 = 4'd11;
    localparam logic [3:0] ADDR_CTRL = 4'd12;
    localparam logic [3:0] ADDR_ID = 4'd13;

    localparam logic [31:0] ID_VALUE = 32'h4145_5331;

    localparam int STATUS_BUSY = 0;
    localparam int STATUS_DONE = 1;
    localparam int STATUS_ERR = 2;
    localparam int STATUS_KEY_SET = 3;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLR_DONE = 1;
    localparam int CTRL_CLR_ERR = 2;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_RSVD = 2'b10;
    localparam logic [1:0] WIDTH_WORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/aes_reg_wmerge.sv
// Merges an SPI write of byte/half/word width into an existing register word.
// Combinational; flags the reserved width so the caller can drop the write.
module aes_reg_wmerge
    import aes_regfile_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  txn_width,
    output logic [31:0] merged,
    output logic        illegal
);

    always_comb begin
        merged  = old_word;
        illegal = 1'b0;
        case (txn_width)
            WIDTH_BYTE: merged[7:0]  = new_data[7:0];
            WIDTH_HALF: merged[15:0] = new_data[15:0];
            WIDTH_WORD: merged       = new_data;
            default:    illegal      = 1'b1;
        endcase
    end

endmodule

// File: rtl/aes_spi_regfile.sv
// SPI-facing register file for the AES-128 core: key/plaintext storage, start/busy/done
// handshake, ciphertext capture. Reads are combinational; all updates gated by ena.
module aes_spi_regfile
    import aes_regfile_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int REG_W  = 32
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena,
    input  logic [ADDR_W-1:0] reg_addr,
    input  logic [REG_W-1:0]  reg_data_o,
    input  logic              reg_data_o_dv,
    input  logic              reg_rw,
    input  logic              reg_addr_v,
    input  logic [1:0]        txn_width,
    output logic [REG_W-1:0]  reg_data_i,
    output logic [7:0]        status,
    output logic [127:0]      core_key,
    output logic [127:0]      core_din,
    output logic              core_start,
    input  logic              core_done,
    input  logic [127:0]      core_dout
);

    logic [31:0] key_q [4];
    logic [31:0] din_q [4];
    logic [31:0] dout_q [4];
    logic [3:0]  key_mask_q;
    logic        done_q, err_q, addr_v_q;
    state_t      state_q, state_d;

    logic [1:0]  region, idx;
    logic [31:0] old_word, merged;
    logic        illegal, busy, key_set;
    logic        wr, wr_ok, key_wr, din_wr, ctrl_wr, start_req, start_ok;
    logic        err_set, err_clr, done_set, done_clr;

    assign region  = reg_addr[3:2];
    assign idx     = reg_addr[1:0];
    assign busy    = (state_q != IDLE);
    assign key_set = &key_mask_q;

    always_comb begin
        old_word = 32'h0;
        case (region)
            2'd0:    old_word = key_q[idx];
            2'd1:    old_word = din_q[idx];
            default: old_word = 32'h0;
        endcase
    end

    aes_reg_wmerge u_wmerge (
        .old_word  (old_word),
        .new_data  (reg_data_o),
        .txn_width (txn_width),
        .merged    (merged),
        .illegal   (illegal)
    );

    always_comb begin
        wr        = ena & reg_data_o_dv & reg_rw;
        wr_ok     = wr & ~illegal;
        key_wr    = wr_ok & (region == 2'd0) & ~busy;
        din_wr    = wr_ok & (region == 2'd1) & ~busy;
        ctrl_wr   = wr_ok & (reg_addr == ADDR_CTRL);
        start_req = ctrl_wr & merged[CTRL_START];
        start_ok  = start_req & ~busy & key_set;
        // Every rejected write flags err: bad width, busy, read-only or unmapped target.
        err_set   = (wr & illegal)
                  | (wr_ok & ((region == 2'd0) | (region == 2'd1)) & busy)
                  | (wr_ok & (region == 2'd2))
                  | (wr_ok & (region == 2'd3) & (reg_addr != ADDR_CTRL))
                  | (start_req & ~start_ok);
        err_clr   = ctrl_wr & merged[CTRL_CLR_ERR];
        done_set  = ena & core_done & (state_q == WAIT);
        done_clr  = (ctrl_wr & merged[CTRL_CLR_DONE])
                  | (ena & reg_addr_v & ~addr_v_q & (reg_addr == ADDR_DOUT3));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = START;
            START:   if (ena) state_d = WAIT;
            WAIT:    if (done_set) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            for (int i = 0; i < 4; i++) begin
                key_q[i]  <= 32'h0;
                din_q[i]  <= 32'h0;
                dout_q[i] <= 32'h0;
            end
            key_mask_q <= 4'h0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            addr_v_q   <= 1'b0;
            state_q    <= IDLE;
        end else begin
            state_q <= state_d;
            if (ena) begin
                addr_v_q <= reg_addr_v;
                if (key_wr) begin
                    key_q[idx]      <= merged;
                    key_mask_q[idx] <= 1'b1;
                end
                if (din_wr) din_q[idx] <= merged;
                if (done_set) begin
                    for (int i = 0; i < 4; i++) dout_q[i] <= core_dout[32*i +: 32];
                end
                // Set has priority over clear for both sticky flags.
                if (done_set)      done_q <= 1'b1;
                else if (done_clr) done_q <= 1'b0;
                if (err_set)       err_q <= 1'b1;
                else if (err_clr)  err_q <= 1'b0;
            end
        end
    end

    always_comb begin
        reg_data_i = '0;
        case (region)
            2'd1: reg_data_i = din_q[idx];
            2'd2: reg_data_i = dout_q[idx];
            2'd3: begin
                if (reg_addr == ADDR_CTRL)    reg_data_i = {29'b0, err_q, done_q, busy};
                else if (reg_addr == ADDR_ID) reg_data_i = ID_VALUE;
            end
            default: reg_data_i = '0;
        endcase
    end

    always_comb begin
        status                 = 8'h00;
        status[STATUS_BUSY]    = busy;
        status[STATUS_DONE]    = done_q;
        status[STATUS_ERR]     = err_q;
        status[STATUS_KEY_SET] = key_set;
    end

    assign core_key   = {key_q[3], key_q[2], key_q[1], key_q[0]};
    assign core_din   = {din_q[3], din_q[2], din_q[1], din_q[0]};
    assign core_start = (state_q == START);

endmodule

// File: tb/tb_aes_spi_regfile.sv
// Self-checking bench for aes_spi_regfile against a behavioural register-map model.
module tb_aes_spi_regfile;

    logic         clk = 1'b0;
    logic         rstb, ena;
    logic [3:0]   reg_addr;
    logic [31:0]  reg_data_o;
    logic         reg_data_o_dv, reg_rw, reg_addr_v;
    logic [1:0]   txn_width;
    logic [31:0]  reg_data_i;
    logic [7:0]   status;
    logic [127:0] core_key, core_din, core_dout;
    logic         core_start, core_done;

    aes_spi_regfile dut (
        .clk           (clk),
        .rstb          (rstb),
        .ena           (ena),
        .reg_addr      (reg_addr),
        .reg_data_o    (reg_data_o),
        .reg_data_o_dv (reg_data_o_dv),
        .reg_rw        (reg_rw),
        .reg_addr_v    (reg_addr_v),
        .txn_width     (txn_width),
        .reg_data_i    (reg_data_i),
        .status        (status),
        .core_key      (core_key),
        .core_din      (core_din),
        .core_start    (core_start),
        .core_done     (core_done),
        .core_dout     (core_dout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;
    int exp_starts = 0;

    always @(negedge clk) if (core_start === 1'b1) start_cnt++;

    // Behavioural model of the register map
    logic [31:0] m_key [4];
    logic [31:0] m_din [4];
    logic [31:0] m_dout [4];
    bit          m_mask [4];
    bit          m_done, m_err, m_busy;

    localparam logic [127:0] CT = 128'h3925_841D_02DC_09FB_DC11_8597_196A_0B32;

    function automatic bit m_keyset();
        return m_mask[0] & m_mask[1] & m_mask[2] & m_mask[3];
    endfunction

    function automatic logic [7:0] exp_status();
        return {4'b0, m_keyset(), m_err, m_done, m_busy};
    endfunction

    function automatic logic [31:0] exp_read(input int a);
        if (a < 4) return 32'h0;
        if (a < 8) return m_din[a-4];
        if (a < 12) return m_dout[a-8];
        if (a == 12) return {29'b0, m_err, m_done, m_busy};
        if (a == 13) return 32'h4145_5331;
        return 32'h0;
    endfunction

    function automatic logic [127:0] exp_key();
        return {m_key[3], m_key[2], m_key[1], m_key[0]};
    endfunction

    function automatic logic [127:0] exp_din();
        return {m_din[3], m_din[2], m_din[1], m_din[0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [1:0] w);
        logic [31:0] m;
        m = (w == 2'b00) ? 32'h0000_00FF : (w == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        return (old & ~m) | (d & m);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_key[i] = 0; m_din[i] = 0; m_dout[i] = 0; m_mask[i] = 0;
        end
        m_done = 0; m_err = 0; m_busy = 0;
    endfunction

    function automatic void model_write(input int a, input logic [31:0] d, input logic [1:0] w);
        bit eset, eclr;
        eset = 0; eclr = 0;
        if (w == 2'b10) begin
            m_err = 1;
            return;
        end
        if (a < 4) begin
            if (m_busy) eset = 1;
            else begin m_key[a] = merge(m_key[a], d, w); m_mask[a] = 1; end
        end else if (a < 8) begin
            if (m_busy) eset = 1;
            else m_din[a-4] = merge(m_din[a-4], d, w);
        end else if (a == 12) begin
            if (d[0]) begin
                if (m_busy || !m_keyset()) eset = 1;
                else begin m_busy = 1; exp_starts++; end
            end
            if (d[1]) m_done = 0;
            eclr = d[2];
        end else eset = 1;
        if (eset) m_err = 1;
        else if (eclr) m_err = 0;
    endfunction

    function automatic void model_done(input logic [127:0] dv);
        if (m_busy) begin
            for (int i = 0; i < 4; i++) m_dout[i] = dv[32*i +: 32];
            m_done = 1;
            m_busy = 0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [1:0] w);
        reg_addr = 4'(a); reg_data_o = d; txn_width = w;
        reg_rw = 1; reg_data_o_dv = 1;
        tick();
        reg_data_o_dv = 0; reg_rw = 0;
        model_write(a, d, w);
    endtask

    task automatic do_reset();
        rstb = 0;
        tick();
        rstb = 1;
        model_reset();
    endtask

    task automatic pulse_done(input logic [127:0] dv);
        core_done = 1; core_dout = dv;
        tick();
        core_done = 0;
        model_done(dv);
    endtask

    task automatic test_reset();
        wr(0, 32'hFFFF_FFFF, 2'b11);
        checks++;
        if (core_key !== exp_key()) begin
            failures++; $display("FAIL key0_write got=%h want=%h", core_key, exp_key());
        end
        do_reset();
        checks++;
        if (status !== 8'h00) begin failures++; $display("FAIL reset_status got=%h want=00", status); end
        checks++;
        if (core_key !== 128'h0 || core_start !== 1'b0) begin
            failures++; $display("FAIL reset_key got=%h start=%b want=0", core_key, core_start);
        end
        reg_addr = 4'd0; #1;
        checks++;
        if (reg_data_i !== 32'h0) begin failures++; $display("FAIL reset_key0_read got=%h want=0", reg_data_i); end
        reg_addr = 4'd13; #1;
        checks++;
        if (reg_data_i !== 32'h4145_5331) begin failures++; $display("FAIL id_read got=%h want=41455331", reg_data_i); end
    endtask

    task automatic test_width_merge();
        logic [31:0] want [3];
        want[0] = 32'h1122_3344; want[1] = 32'h1122_33AA; want[2] = 32'h1122_BEEF;
        wr(4, 32'h1122_3344, 2'b11);
        wr(4, 32'h5566_77AA, 2'b00);
        reg_addr = 4'd4; #1;
        checks++;
        if (reg_data_i !== want[1]) begin failures++; $display("FAIL merge_byte got=%h want=%h", reg_data_i, want[1]); end
        wr(4, 32'h9988_BEEF, 2'b01);
        reg_addr = 4'd4; #1;
        checks++;
        if (reg_data_i !== want[2]) begin failures++; $display("FAIL merge_half got=%h want=%h", reg_data_i, want[2]); end
        wr(4, 32'h0000_0000, 2'b10);
        reg_addr = 4'd4; #1;
        checks++;
        if (reg_data_i !== want[2] || status[2] !== 1'b1) begin
            failures++; $display("FAIL merge_rsvd got=%h err=%b want=%h err=1", reg_data_i, status[2], want[2]);
        end
        wr(12, 32'h4, 2'b11);
        checks++;
        if (status !== exp_status()) begin failures++; $display("FAIL err_clear got=%h want=%h", status, exp_status()); end
    endtask

    task automatic test_random_rw();
        int a;
        logic [31:0] d;
        logic [1:0] w;
        for (int n = 0; n < 60; n++) begin
            a = $urandom_range(0, 14);
            if (a >= 12) a++;
            w = 2'($urandom_range(0, 3));
            d = $urandom;
            wr(a, d, w);
            reg_addr = 4'(a); #1;
            checks++;
            if (reg_data_i !== exp_read(a) || status !== exp_status() ||
                core_key !== exp_key() || core_din !== exp_din()) begin
                failures++;
                $display("FAIL rand_rw[%0d] a=%0d rd=%h/%h st=%h/%h key=%h/%h din=%h/%h", n, a,
                         reg_data_i, exp_read(a), status, exp_status(), core_key, exp_key(), core_din, exp_din());
            end
        end
    endtask

    task automatic test_start_no_key();
        do_reset();
        for (int i = 0; i < 3; i++) wr(i, $urandom, 2'b11);
        wr(12, 32'h1, 2'b11);
        repeat (3) tick();
        checks++;
        if (start_cnt !== exp_starts || status !== 8'h04) begin
            failures++; $display("FAIL start_no_key starts=%0d/%0d status=%h want=04", start_cnt, exp_starts, status);
        end
    endtask

    task automatic test_full_op();
        logic [31:0] din1_before;
        do_reset();
        for (int i = 0; i < 4; i++) wr(i, $urandom, 2'b11);
        for (int i = 0; i < 4; i++) wr(4 + i, $urandom, 2'b11);
        checks++;
        if (core_key !== exp_key() || core_din !== exp_din()) begin
            failures++; $display("FAIL core_ports key=%h/%h din=%h/%h", core_key, exp_key(), core_din, exp_din());
        end
        wr(12, 32'h1, 2'b11);
        checks++;
        if (core_start !== 1'b1 || status !== 8'h09) begin
            failures++; $display("FAIL start_pulse start=%b status=%h want start=1 status=09", core_start, status);
        end
        tick();
        checks++;
        if (core_start !== 1'b0 || start_cnt !== exp_starts) begin
            failures++; $display("FAIL start_once start=%b cnt=%0d want 0 cnt=%0d", core_start, start_cnt, exp_starts);
        end
        din1_before = m_din[1];
        wr(5, ~din1_before, 2'b11);
        wr(12, 32'h1, 2'b11);
        repeat (2) tick();
        reg_addr = 4'd5; #1;
        checks++;
        if (reg_data_i !== din1_before || start_cnt !== exp_starts || status !== 8'h0D) begin
            failures++; $display("FAIL busy_protect din1=%h/%h starts=%0d/%0d status=%h want 0D",
                                 reg_data_i, din1_before, start_cnt, exp_starts, status);
        end
        wr(12, 32'h4, 2'b11);
        checks++;
        if (status !== 8'h09) begin failures++; $display("FAIL busy_err_clear got=%h want=09", status); end
        pulse_done(CT);
        reg_addr = 4'd8; #1;
        checks++;
        if (reg_data_i !== 32'h196A_0B32 || status !== 8'h0A) begin
            failures++; $display("FAIL done_capture dout0=%h status=%h want 196a0b32 0a", reg_data_i, status);
        end
        for (int i = 1; i < 4; i++) begin
            reg_addr = 4'(8 + i); #1;
            checks++;
            if (reg_data_i !== exp_read(8 + i)) begin
                failures++; $display("FAIL dout%0d got=%h want=%h", i, reg_data_i, exp_read(8 + i));
            end
        end
    endtask

    task automatic test_done_clear();
        logic [127:0] dv;
        reg_rw = 0;
        reg_addr = 4'd10; reg_addr_v = 1;
        repeat (2) tick();
        reg_addr_v = 0;
        tick();
        checks++;
        if (status[1] !== 1'b1) begin failures++; $display("FAIL done_other_read got=%b want=1", status[1]); end
        reg_addr = 4'd11; reg_addr_v = 1;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c == 0) m_done = 0;
            checks++;
            if (status !== exp_status() || reg_data_i !== exp_read(11)) begin
                failures++; $display("FAIL done_read_clr[%0d] status=%h/%h rd=%h/%h", c, status, exp_status(), reg_data_i, exp_read(11));
            end
        end
        reg_addr_v = 0;
        wr(12, 32'h1, 2'b11);
        tick();
        dv = {$urandom, $urandom, $urandom, $urandom};
        reg_addr = 4'd12; reg_data_o = 32'h2; txn_width = 2'b11; reg_rw = 1; reg_data_o_dv = 1;
        core_done = 1; core_dout = dv;
        tick();
        reg_data_o_dv = 0; reg_rw = 0; core_done = 0;
        model_write(12, 32'h2, 2'b11);
        model_done(dv);
        reg_addr = 4'd9; #1;
        checks++;
        if (status !== 8'h0A || reg_data_i !== dv[63:32]) begin
            failures++; $display("FAIL done_set_wins status=%h rd=%h want 0a %h", status, reg_data_i, dv[63:32]);
        end
        pulse_done(~dv);
        reg_addr = 4'd8; #1;
        checks++;
        if (reg_data_i !== exp_read(8) || status !== exp_status()) begin
            failures++; $display("FAIL done_idle_ignored rd=%h/%h status=%h/%h", reg_data_i, exp_read(8), status, exp_status());
        end
    endtask

    task automatic test_reset_mid_op();
        wr(12, 32'h1, 2'b11);
        tick();
        do_reset();
        pulse_done(CT);
        reg_addr = 4'd8; #1;
        checks++;
        if (status !== 8'h00 || reg_data_i !== 32'h0 || core_start !== 1'b0) begin
            failures++; $display("FAIL reset_mid_op status=%h dout0=%h start=%b want 00 0 0", status, reg_data_i, core_start);
        end
    endtask

    initial begin
        rstb = 0; ena = 1; reg_addr = 0; reg_data_o = 0; reg_data_o_dv = 0;
        reg_rw = 0; reg_addr_v = 0; txn_width = 2'b11; core_done = 0; core_dout = 0;
        model_reset();
        repeat (3) tick();
        rstb = 1;
        tick();
        test_reset();
        test_width_merge();
        test_random_rw();
        test_start_no_key();
        test_full_op();
        test_done_clear();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
